// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg
// Shared constants and types for the MiniMIPS32 PC generation stage.
//   ZERO_WORD     : all-zero 32-bit word
//   CHIP_ENABLE   : fetch enable asserted level
//   CHIP_DISABLE  : fetch enable deasserted level
//   BOOT_VECTOR   : MIPS boot vector, default reset PC
//   pc_state_t    : BOOT / RUN state encoding for the PC FSM
package pc_gen_pkg;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam logic [31:0] BOOT_VECTOR  = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_gen_branch_buf.sv
// pc_branch_buf
// Holds one branch redirect that arrived while the front end was stalled,
// so it can be applied on the first unstalled cycle.
// Ports:
//   clk            in   pipeline clock
//   rst            in   synchronous active-high reset
//   capture        in   request to store capture_target (ignored if full)
//   capture_target in   branch target to store
//   clear          in   drop the buffered branch (it was used or overridden)
//   flush          in   exception/ERET redirect, drops the buffered branch
//   pend_valid     out  buffer holds a branch
//   pend_target    out  buffered branch target
module pc_branch_buf
  import pc_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic [31:0] capture_target,
  input  logic        clear,
  input  logic        flush,
  output logic        pend_valid,
  output logic [31:0] pend_target
);

  // Reset, flush and clear all empty the buffer. Only the first branch
  // seen during a stall is kept: once full, later captures are ignored
  // because the oldest redirect is the architecturally correct one.
  always_ff @(posedge clk) begin
    if (rst || flush || clear) begin
      pend_valid  <= 1'b0;
      pend_target <= ZERO_WORD;
    end else if (capture && !pend_valid) begin
      pend_valid  <= 1'b1;
      pend_target <= capture_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen
// Program-counter generation stage of the MiniMIPS32 pipeline. Holds the
// fetch PC and selects the next PC from flush, live branch, buffered branch
// or sequential PC+4.
// Optional feature macro: PC_FETCH_CNT_EN adds the fetch_cnt_o counter.
// Ports:
//   clk             in   pipeline clock
//   rst             in   synchronous active-high reset
//   stall_i         in   fetch stall, PC holds
//   flush_i         in   exception/ERET redirect, highest priority
//   new_pc_i        in   redirect target valid with flush_i
//   branch_flag_i   in   taken branch/jump resolved in ID
//   branch_target_i in   branch target valid with branch_flag_i
//   pc_o            out  fetch address
//   ce_o            out  fetch enable
//   fetch_cnt_o     out  issued-fetch counter (PC_FETCH_CNT_EN only)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = BOOT_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
`ifdef PC_FETCH_CNT_EN
  output logic [31:0] fetch_cnt_o,
`endif
  output logic [31:0] pc_o,
  output logic        ce_o
);

  pc_state_t   state;
  logic        buf_capture;
  logic        buf_clear;
  logic        buf_flush;
  logic        pend_valid;
  logic [31:0] pend_target;

  // Buffer control mirrors the next-PC priority below: flush wins, a stall
  // may capture a branch, and any unstalled RUN cycle consumes or drops
  // whatever is buffered (a live branch beats a buffered one). In BOOT the
  // buffer is left alone, which after reset means it stays empty.
  always_comb begin
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    buf_flush   = 1'b0;
    if (state == RUN) begin
      if (flush_i) begin
        buf_flush = 1'b1;
      end else if (stall_i) begin
        buf_capture = branch_flag_i;
      end else begin
        buf_clear = 1'b1;
      end
    end
  end

  pc_branch_buf u_branch_buf (
    .clk            (clk),
    .rst            (rst),
    .capture        (buf_capture),
    .capture_target (branch_target_i),
    .clear          (buf_clear),
    .flush          (buf_flush),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target)
  );

  // PC FSM. BOOT spends one cycle with fetch disabled at the reset PC and
  // ignores all redirect inputs; RUN issues fetches and picks the next PC.
  // Targets are loaded as-is; misalignment is the fetch stage's problem.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_o  <= RESET_PC;
      ce_o  <= CHIP_DISABLE;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          ce_o  <= CHIP_ENABLE;
        end
        RUN: begin
          ce_o <= CHIP_ENABLE;
          if (flush_i) begin
            pc_o <= new_pc_i;
          end else if (stall_i) begin
            pc_o <= pc_o;
          end else if (branch_flag_i) begin
            pc_o <= branch_target_i;
          end else if (pend_valid) begin
            pc_o <= pend_target;
          end else begin
            pc_o <= pc_o + PC_STEP;
          end
        end
        default: begin
          state <= BOOT;
          pc_o  <= RESET_PC;
          ce_o  <= CHIP_DISABLE;
        end
      endcase
    end
  end

`ifdef PC_FETCH_CNT_EN
  // Counts edges that actually advance the fetch stream: RUN, not stalled,
  // not flushed. Wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= ZERO_WORD;
    end else if (state == RUN && !stall_i && !flush_i) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen
// Self-checking bench for pc_gen. Each scenario task drives a list of
// per-cycle stimuli, pushes the expected pc_o/ce_o after that edge into a
// scoreboard queue, and pops/compares one entry per clock edge.
// Define PC_FETCH_CNT_EN to also exercise the fetch counter.
module tb_pc_gen;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        exp_ce;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        ce;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o;
  logic        ce_o;
`ifdef PC_FETCH_CNT_EN
  logic [31:0] fetch_cnt_o;
`endif

  int   checks;
  int   errors;
  exp_t exp_q[$];

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
`ifdef PC_FETCH_CNT_EN
    .fetch_cnt_o     (fetch_cnt_o),
`endif
    .pc_o            (pc_o),
    .ce_o            (ce_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t mk(input logic r, input logic s, input logic f,
                               input logic [31:0] np, input logic b,
                               input logic [31:0] t, input logic [31:0] epc,
                               input logic ece);
    stim_t x;
    x.rst = r; x.stall = s; x.flush = f; x.new_pc = np;
    x.br = b; x.tgt = t; x.exp_pc = epc; x.exp_ce = ece;
    return x;
  endfunction

  // Applies one cycle of stimulus, queues its expectation, waits past the edge.
  task automatic drive(input stim_t s);
    exp_t e;
    rst             = s.rst;
    stall_i         = s.stall;
    flush_i         = s.flush;
    new_pc_i        = s.new_pc;
    branch_flag_i   = s.br;
    branch_target_i = s.tgt;
    e.pc = s.exp_pc;
    e.ce = s.exp_ce;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0));
    st.push_back(mk(1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL reset[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_branch;
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_000C, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 32'hBFC0_0100, 32'hBFC0_0100, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0104, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL branch[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_stalled_branch;
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 1, 0, 0, 1, 32'h8000_0040, 32'hBFC0_0104, 1));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0104, 1));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0104, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h8000_0040, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h8000_0044, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL stalled_branch[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_flush_priority;
    stim_t st[$];
    exp_t  e;
    // Buffer a branch, flush under stall, then prove the buffer was emptied.
    st.push_back(mk(0, 1, 0, 0, 1, 32'h8000_0040, 32'h8000_0044, 1));
    st.push_back(mk(0, 1, 1, 32'hBFC0_0380, 0, 0, 32'hBFC0_0380, 1));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0380, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0384, 1));
    // Simultaneous flush and branch: flush target wins, branch dropped.
    st.push_back(mk(0, 0, 1, 32'hBFC0_0200, 1, 32'h1234_5678, 32'hBFC0_0200, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0204, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL flush_priority[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_wrap_misalign;
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_0000, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_0004, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 32'h8000_0002, 32'h8000_0002, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h8000_0006, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL wrap_misalign[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t st[$];
    exp_t  e;
    // Consecutive live branches.
    st.push_back(mk(0, 0, 0, 0, 1, 32'h0000_1000, 32'h0000_1000, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 32'h0000_2000, 32'h0000_2000, 1));
    // Live branch on the release cycle beats the buffered one.
    st.push_back(mk(0, 1, 0, 0, 1, 32'h0000_3000, 32'h0000_2000, 1));
    st.push_back(mk(0, 0, 0, 0, 1, 32'h0000_4000, 32'h0000_4000, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_4004, 1));
    // Second capture while buffer full is ignored: oldest target kept.
    st.push_back(mk(0, 1, 0, 0, 1, 32'h0000_5000, 32'h0000_4004, 1));
    st.push_back(mk(0, 1, 0, 0, 1, 32'h0000_6000, 32'h0000_4004, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_5000, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_5004, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL back_to_back[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

  task automatic test_reset_mid;
    stim_t st[$];
    exp_t  e;
    // Buffer a branch, then reset together with a flush: reset wins,
    // BOOT ignores redirects, and the buffered branch is gone.
    st.push_back(mk(0, 1, 0, 0, 1, 32'h0000_7000, 32'h0000_5004, 1));
    st.push_back(mk(1, 1, 1, 32'h0000_9000, 0, 0, 32'hBFC0_0000, 0));
    st.push_back(mk(0, 0, 1, 32'h0000_9000, 1, 32'h0000_A000, 32'hBFC0_0000, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL reset_mid[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
    end
  endtask

`ifdef PC_FETCH_CNT_EN
  task automatic test_fetch_cnt;
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 1));
    // 10 RUN edges: stalls at 3 and 4, flush at 7 -> 7 counted fetches.
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0004, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0008, 1));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0008, 1));
    st.push_back(mk(0, 1, 0, 0, 0, 0, 32'hBFC0_0008, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_000C, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0010, 1));
    st.push_back(mk(0, 0, 1, 32'hBFC0_0380, 0, 0, 32'hBFC0_0380, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0384, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_0388, 1));
    st.push_back(mk(0, 0, 0, 0, 0, 0, 32'hBFC0_038C, 1));
    foreach (st[i]) begin
      drive(st[i]);
      e = exp_q.pop_front();
      checks++;
      if (pc_o !== e.pc || ce_o !== e.ce) begin
        errors++;
        $display("[TB] FAIL fetch_cnt_pc[%0d]: pc=%h ce=%b required pc=%h ce=%b", i, pc_o, ce_o, e.pc, e.ce);
      end
      if (i == 1) begin
        checks++;
        if (fetch_cnt_o !== 32'd0) begin
          errors++;
          $display("[TB] FAIL fetch_cnt_boot: cnt=%0d required 0", fetch_cnt_o);
        end
      end
    end
    checks++;
    if (fetch_cnt_o !== 32'd7) begin
      errors++;
      $display("[TB] FAIL fetch_cnt_run: cnt=%0d required 7", fetch_cnt_o);
    end
    drive(mk(1, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0));
    e = exp_q.pop_front();
    checks++;
    if (fetch_cnt_o !== 32'd0 || pc_o !== e.pc || ce_o !== e.ce) begin
      errors++;
      $display("[TB] FAIL fetch_cnt_reset: cnt=%0d pc=%h ce=%b required cnt=0 pc=%h ce=%b",
               fetch_cnt_o, pc_o, ce_o, e.pc, e.ce);
    end
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    stall_i         = 1'b0;
    flush_i         = 1'b0;
    new_pc_i        = 32'h0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_branch();
    test_stalled_branch();
    test_flush_priority();
    test_wrap_misalign();
    test_back_to_back();
    test_reset_mid();
`ifdef PC_FETCH_CNT_EN
    test_fetch_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
